// File: rtl/activation_flow_controller_pkg.sv
// Shared TPU return-path types: instruction word, address types, activation
// function encodings and the tag that rides the write-delay line.
package activation_flow_controller_pkg;

  // Activation opcodes carry this prefix in opcode[7:4]. Bit 4 is reused as the
  // signedness flag, so the prefix test only looks at opcode[7:5].
  localparam logic [3:0] ACT_OPCODE_PREFIX = 4'b1000;

  localparam logic [3:0] ACT_NONE    = 4'd0;
  localparam logic [3:0] ACT_RELU    = 4'd1;
  localparam logic [3:0] ACT_TANH    = 4'd2;
  localparam logic [3:0] ACT_SIGMOID = 4'd3;

  typedef logic [15:0] accumulator_addr_type;
  typedef logic [23:0] buffer_addr_type;

  typedef struct packed {
    logic [7:0]           opcode;
    logic [15:0]          length;
    accumulator_addr_type acc_addr;
    buffer_addr_type      buffer_addr;
  } instr_type;

  typedef struct packed {
    logic            valid;
    buffer_addr_type addr;
    logic [3:0]      func;
    logic            is_signed;
  } act_tag_type;

  typedef enum logic {IDLE, ISSUE} afc_state_e;

  function automatic logic is_act_opcode(input logic [7:0] op);
    return op[7:5] == ACT_OPCODE_PREFIX[3:1];
  endfunction

endpackage

// File: rtl/activation_flow_controller_if.sv
// Bus between the control coordinator and the activation flow controller.
// master: coordinator side (drives instr/instr_enable, observes datapath strobes)
// slave : controller side
// With ACT_FLOW_PERF_COUNTER_EN defined the bus also carries words_written.
interface activation_flow_controller_if;
  import activation_flow_controller_pkg::*;

  instr_type            instr;
  logic                 instr_enable;
  accumulator_addr_type acc_to_act_addr;
  logic                 acc_read_enable;
  logic [3:0]           activation_function;
  logic                 is_signed;
  buffer_addr_type      act_to_buf_addr;
  logic                 buf_write_enable;
  logic                 busy;
  logic                 resource_busy;
`ifdef ACT_FLOW_PERF_COUNTER_EN
  logic [31:0]          words_written;
`endif

  modport master (
    output instr, instr_enable,
    input  acc_to_act_addr, acc_read_enable, activation_function, is_signed,
           act_to_buf_addr, buf_write_enable, busy, resource_busy
`ifdef ACT_FLOW_PERF_COUNTER_EN
    , input words_written
`endif
  );

  modport slave (
    input  instr, instr_enable,
    output acc_to_act_addr, acc_read_enable, activation_function, is_signed,
           act_to_buf_addr, buf_write_enable, busy, resource_busy
`ifdef ACT_FLOW_PERF_COUNTER_EN
    , output words_written
`endif
  );

endinterface

// File: rtl/activation_flow_controller_act_delay_line.sv
// act_delay_line: DEPTH-stage shift register of act_tag_type covering the
// accumulator read + activation latency. Advances only when en=1.
// Ports: clk, rst (async, active-low), en, din (tag pushed each advance),
//        dout (tail stage), any_valid (OR of all stage valid bits).
module act_delay_line
  import activation_flow_controller_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  act_tag_type din,
  output act_tag_type dout,
  output logic        any_valid
);

  act_tag_type pipe [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | pipe[i].valid;
  end

endmodule

// File: rtl/activation_flow_controller.sv
// activation_flow_controller: TPU return path. Issues accumulator reads for an
// instruction (acc_addr is source, buffer_addr destination), and after
// TOTAL_LATENCY enabled cycles writes each activated row to the unified buffer.
// Ports: clk, rst (async, active-low), enable (global advance/stall),
//        bus (activation_flow_controller_if.slave): instr/instr_enable in;
//        read/write strobes+addresses, function/sign tags, busy, resource_busy out.
// Optional: ACT_FLOW_PERF_COUNTER_EN adds a saturating words_written counter.
module activation_flow_controller
  import activation_flow_controller_pkg::*;
#(
  parameter int ACC_READ_LATENCY   = 2,
  parameter int ACTIVATION_LATENCY = 3
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         enable,
  activation_flow_controller_if.slave bus
);

  localparam int TOTAL_LATENCY = ACC_READ_LATENCY + ACTIVATION_LATENCY;

  afc_state_e           state, nxt;
  instr_type            cur;
  logic [15:0]          count;
  logic                 accept, issue, last;
  act_tag_type          push, tail;
  logic                 line_valid;
  logic                 busy_q, rd_q, wr_q, sign_q;
  accumulator_addr_type rd_addr_q;
  buffer_addr_type      wr_addr_q;
  logic [3:0]           func_q;

  // busy_q also covers the cycle after the last read, so an instruction
  // can't be taken until the strobe for the final read has been seen.
  assign accept = enable && (state == IDLE) && !busy_q && bus.instr_enable;
  assign issue  = enable && (state == ISSUE);
  assign last   = (count == cur.length - 16'd1);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept && (bus.instr.length != 16'd0)) nxt = ISSUE;
      ISSUE:   if (issue && last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    push           = '0;
    push.valid     = issue;
    push.addr      = cur.buffer_addr + {8'd0, count};
    push.func      = cur.opcode[3:0];
    push.is_signed = cur.opcode[4];
  end

  act_delay_line #(.DEPTH(TOTAL_LATENCY)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .en       (enable),
    .din      (push),
    .dout     (tail),
    .any_valid(line_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      count     <= '0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      func_q    <= '0;
      sign_q    <= 1'b0;
    end else if (!enable) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt == ISSUE) || (state == ISSUE);
      if (accept) begin
        cur   <= bus.instr;
        count <= '0;
      end else if (issue) begin
        count <= count + 16'd1;
      end
      rd_q <= issue;
      if (issue) rd_addr_q <= cur.acc_addr + count;
      wr_q <= tail.valid;
      if (tail.valid) wr_addr_q <= tail.addr;
      // A write leaving the line shows its own tag so a draining instruction
      // stays correctly labelled while the next one is issuing.
      if (tail.valid) begin
        func_q <= tail.func;
        sign_q <= tail.is_signed;
      end else if (accept) begin
        func_q <= bus.instr.opcode[3:0];
        sign_q <= bus.instr.opcode[4];
      end else if (state == ISSUE) begin
        func_q <= cur.opcode[3:0];
        sign_q <= cur.opcode[4];
      end
    end
  end

  assign bus.acc_read_enable     = rd_q;
  assign bus.acc_to_act_addr     = rd_addr_q;
  assign bus.buf_write_enable    = wr_q;
  assign bus.act_to_buf_addr     = wr_addr_q;
  assign bus.activation_function = func_q;
  assign bus.is_signed           = sign_q;
  assign bus.busy                = busy_q;
  assign bus.resource_busy       = busy_q | line_valid | wr_q;

`ifdef ACT_FLOW_PERF_COUNTER_EN
  logic [31:0] words_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) words_q <= '0;
    else if (enable && tail.valid && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
  end
  assign bus.words_written = words_q;
`endif

endmodule

// File: tb/tb_activation_flow_controller.sv
// Scoreboard bench for activation_flow_controller: the stimulus pushes expected
// read addresses and write tags into queues; a monitor pops and compares on
// every strobe. Directed timing/state checks run alongside.
module tb_activation_flow_controller;
  import activation_flow_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n_rd = 0;
  int   n_wr = 0;

  logic [15:0] exp_rd [$];
  logic [28:0] exp_wr [$];

  activation_flow_controller_if ifc();

  activation_flow_controller dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    if (ifc.acc_read_enable) begin
      n_rd++;
      if (exp_rd.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got addr %0h with nothing expected", ifc.acc_to_act_addr);
      end else chk("rd_addr", 32'(ifc.acc_to_act_addr), 32'(exp_rd.pop_front()));
    end
    if (ifc.buf_write_enable) begin
      n_wr++;
      if (exp_wr.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr_unexpected: got addr %0h with nothing expected", ifc.act_to_buf_addr);
      end else chk("wr_addr_func_sign",
                   32'({ifc.act_to_buf_addr, ifc.activation_function, ifc.is_signed}),
                   32'(exp_wr.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] len, input logic [15:0] acc,
                       input logic [23:0] ba, input bit model);
    ifc.instr        = '{opcode: op, length: len, acc_addr: acc, buffer_addr: ba};
    ifc.instr_enable = 1'b1;
    if (model)
      for (int i = 0; i < int'(len); i++) begin
        exp_rd.push_back(acc + 16'(i));
        exp_wr.push_back({ba + 24'(i), op[3:0], op[4]});
      end
    tick();
    ifc.instr_enable = 1'b0;
  endtask

  task automatic wait_reads(input int target);
    for (int g = 0; g < 300 && n_rd < target; g++) tick();
    chk("wait_reads", 32'(n_rd), 32'(target));
  endtask

  task automatic wait_writes(input int target);
    for (int g = 0; g < 300 && n_wr < target; g++) tick();
    chk("wait_writes", 32'(n_wr), 32'(target));
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 300 && ifc.resource_busy; g++) tick();
    chk("idle", 32'(ifc.resource_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b_rd, b_wr;
    ifc.instr = '0;
    ifc.instr_enable = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_rd_en", 32'(ifc.acc_read_enable), 32'd0);
    chk("rst_wr_en", 32'(ifc.buf_write_enable), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_rbusy", 32'(ifc.resource_busy), 32'd0);
    chk("rst_func", 32'(ifc.activation_function), 32'd0);
    rst = 1'b1;
    tick();

    // Basic run: sigmoid, signed, 29 rows
    issue(8'b1001_0011, 16'd29, 16'h0049, 24'h009463, 1'b1);
    chk("busy_rise", 32'(ifc.busy), 32'd1);
    chk("no_rd_at_accept", 32'(ifc.acc_read_enable), 32'd0);
    tick();
    chk("first_rd", 32'(ifc.acc_read_enable), 32'd1);
    chk("func", 32'(ifc.activation_function), 32'd3);
    chk("signed", 32'(ifc.is_signed), 32'd1);
    k = 0;
    while (!ifc.buf_write_enable && k < 20) begin tick(); k++; end
    chk("wr_latency", 32'(k), 32'd5);
    wait_reads(29);
    chk("busy_at_last_rd", 32'(ifc.busy), 32'd1);
    tick();
    chk("busy_fall", 32'(ifc.busy), 32'd0);
    chk("rd_stop", 32'(ifc.acc_read_enable), 32'd0);

    // Back-to-back while the first drain is in flight
    issue(8'b1000_0001, 16'd14, 16'h0006, 24'h0000AB, 1'b1);
    chk("b2b_busy", 32'(ifc.busy), 32'd1);
    wait_writes(43);
    chk("rbusy_at_last_wr", 32'(ifc.resource_busy), 32'd1);
    tick();
    chk("rbusy_fall", 32'(ifc.resource_busy), 32'd0);
    chk("b2b_reads", 32'(n_rd), 32'd43);

    // Stall for 3 cycles after the 2nd read
    b_rd = n_rd; b_wr = n_wr;
    issue(8'b1000_0010, 16'd4, 16'h0100, 24'h000200, 1'b1);
    wait_reads(b_rd + 2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_rd", 32'(ifc.acc_read_enable), 32'd0);
      chk("stall_busy", 32'(ifc.busy), 32'd1);
    end
    enable = 1'b1;
    wait_idle();
    chk("stall_reads", 32'(n_rd - b_rd), 32'd4);
    chk("stall_writes", 32'(n_wr - b_wr), 32'd4);

    // Address wrap, hand-computed expectations
    b_rd = n_rd;
    exp_rd.push_back(16'hFFFE); exp_rd.push_back(16'hFFFF); exp_rd.push_back(16'h0000);
    exp_wr.push_back({24'hFFFFFF, 4'd0, 1'b0});
    exp_wr.push_back({24'h000000, 4'd0, 1'b0});
    exp_wr.push_back({24'h000001, 4'd0, 1'b0});
    issue(8'b1000_0000, 16'd3, 16'hFFFE, 24'hFFFFFF, 1'b0);
    tick();
    wait_idle();
    chk("wrap_reads", 32'(n_rd - b_rd), 32'd3);

    // Zero length: no busy, no strobes
    b_rd = n_rd;
    issue(8'b1000_0001, 16'd0, 16'h1234, 24'h005678, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("zero_busy", 32'(ifc.busy), 32'd0);
      chk("zero_rbusy", 32'(ifc.resource_busy), 32'd0);
      tick();
    end
    chk("zero_reads", 32'(n_rd - b_rd), 32'd0);

    // Strobe with enable low is dropped
    enable = 1'b0;
    issue(8'b1000_0001, 16'd5, 16'h0300, 24'h000300, 1'b0);
    enable = 1'b1;
    tick();
    chk("en_low_strobe_busy", 32'(ifc.busy), 32'd0);

    // Strobe while busy is dropped
    b_rd = n_rd;
    issue(8'b1001_0001, 16'd6, 16'h0400, 24'h000400, 1'b1);
    issue(8'b1000_0011, 16'd5, 16'h0500, 24'h000500, 1'b0);
    tick();
    wait_idle();
    chk("ignored_reads", 32'(n_rd - b_rd), 32'd6);
`ifdef ACT_FLOW_PERF_COUNTER_EN
    chk("words_written", ifc.words_written, 32'(n_wr));
`endif

    // Reset mid-issue
    b_rd = n_rd;
    issue(8'b1000_0001, 16'd20, 16'h0700, 24'h000700, 1'b1);
    wait_reads(b_rd + 5);
    rst = 1'b0;
    #1;
    chk("arst_rd_en", 32'(ifc.acc_read_enable), 32'd0);
    chk("arst_busy", 32'(ifc.busy), 32'd0);
    chk("arst_rbusy", 32'(ifc.resource_busy), 32'd0);
    chk("arst_addr", 32'(ifc.acc_to_act_addr), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    tick();
    rst = 1'b1;
    b_rd = n_rd; b_wr = n_wr;
    for (int i = 0; i < 30; i++) tick();
    chk("post_rst_reads", 32'(n_rd - b_rd), 32'd0);
    chk("post_rst_writes", 32'(n_wr - b_wr), 32'd0);

    chk("rd_leftover", 32'(exp_rd.size()), 32'd0);
    chk("wr_leftover", 32'(exp_wr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
